// File: rtl/dp_tap_pkg.sv
// dp_tap_pkg: TAP state encoding, default IR width and opcodes shared by the TAP controller slice.
package dp_tap_pkg;
  localparam int DEF_IR_W = 4;
  localparam logic [3:0] DEF_OP_EXTEST = 4'h0;
  localparam logic [3:0] DEF_OP_SAMPLE = 4'h1;
  localparam logic [3:0] DEF_OP_BYPASS = 4'hF;
  typedef enum logic [3:0] {
    EXIT2_DR  = 4'h0, EXIT1_DR  = 4'h1, SHIFT_DR = 4'h2, PAUSE_DR = 4'h3,
    SEL_IR    = 4'h4, UPDATE_DR = 4'h5, CAP_DR   = 4'h6, SEL_DR   = 4'h7,
    EXIT2_IR  = 4'h8, EXIT1_IR  = 4'h9, SHIFT_IR = 4'hA, PAUSE_IR = 4'hB,
    RTI       = 4'hC, UPDATE_IR = 4'hD, CAP_IR   = 4'hE, TLR      = 4'hF
  } tap_state_t;
endpackage

// File: rtl/dp_tap_if.sv
// dp_tap_if: JTAG pins plus the control/serial link between the TAP controller and the BSR.
interface dp_tap_if;
  logic       tck_en;
  logic       tms;
  logic       tdi;
  logic       tdo;
  logic       tdo_oe;
  logic       bsr_sdo;
  logic       bsr_sdi;
  logic       mode;
  logic       shift_dr;
  logic       clk_dr;
  logic       update_dr;
  logic [3:0] tap_state;
  modport slave (
    input  tck_en, tms, tdi, bsr_sdo,
    output tdo, tdo_oe, bsr_sdi, mode, shift_dr, clk_dr, update_dr, tap_state
  );
  modport master (
    output tck_en, tms, tdi, bsr_sdo,
    input  tdo, tdo_oe, bsr_sdi, mode, shift_dr, clk_dr, update_dr, tap_state
  );
endinterface

// File: rtl/dp_tap_fsm.sv
// dp_tap_fsm: IEEE 1149.1 16-state TAP graph; advances only on the TCK-rise strobe.
module dp_tap_fsm
  import dp_tap_pkg::*;
(
  input  logic       iclk,
  input  logic       iresetn,
  input  logic       i_tck_en,
  input  logic       i_tms,
  output tap_state_t o_state
);
  tap_state_t r_state;
  tap_state_t w_next;
  always_comb begin
    w_next = TLR;
    case (r_state)
      TLR:       w_next = i_tms ? TLR       : RTI;
      RTI:       w_next = i_tms ? SEL_DR    : RTI;
      SEL_DR:    w_next = i_tms ? SEL_IR    : CAP_DR;
      CAP_DR:    w_next = i_tms ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:  w_next = i_tms ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:  w_next = i_tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:  w_next = i_tms ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:  w_next = i_tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR: w_next = i_tms ? SEL_DR    : RTI;
      SEL_IR:    w_next = i_tms ? TLR       : CAP_IR;
      CAP_IR:    w_next = i_tms ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:  w_next = i_tms ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:  w_next = i_tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:  w_next = i_tms ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:  w_next = i_tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR: w_next = i_tms ? SEL_DR    : RTI;
      default:   w_next = TLR;
    endcase
  end
  always_ff @(posedge iclk or negedge iresetn)
    if (!iresetn) r_state <= TLR;
    else if (i_tck_en) r_state <= w_next;
  assign o_state = r_state;
endmodule

// File: rtl/dp_tap_ctrl.sv
// dp_tap_ctrl: TAP controller sequencing the debug BSR; owns IR, bypass bit, BSR strobes and TDO mux.
module dp_tap_ctrl
  import dp_tap_pkg::*;
#(
  parameter int              IR_W      = DEF_IR_W,
  parameter logic [IR_W-1:0] OP_EXTEST = IR_W'(DEF_OP_EXTEST),
  parameter logic [IR_W-1:0] OP_SAMPLE = IR_W'(DEF_OP_SAMPLE),
  parameter logic [IR_W-1:0] OP_BYPASS = {IR_W{DEF_OP_BYPASS[0]}}
) (
  input logic  iclk,
  input logic  iresetn,
  dp_tap_if.slave bus
);
  tap_state_t      w_state;
  logic [IR_W-1:0] r_ir;
  logic [IR_W-1:0] r_ir_sh;
  logic            r_byp;
  logic            w_bsr_sel;
  logic            w_shd;
  logic            w_shi;
  dp_tap_fsm u_fsm (
    .iclk     (iclk),
    .iresetn  (iresetn),
    .i_tck_en (bus.tck_en),
    .i_tms    (bus.tms),
    .o_state  (w_state)
  );
  // Any opcode other than EXTEST/SAMPLE falls through to bypass.
  assign w_bsr_sel = (r_ir == OP_EXTEST) || (r_ir == OP_SAMPLE);
  assign w_shd     = (w_state == SHIFT_DR);
  assign w_shi     = (w_state == SHIFT_IR);
  always_ff @(posedge iclk or negedge iresetn)
    if (!iresetn) r_ir <= OP_BYPASS;
    else if (w_state == TLR) r_ir <= OP_BYPASS;
    else if (bus.tck_en && w_state == UPDATE_IR) r_ir <= r_ir_sh;
  always_ff @(posedge iclk or negedge iresetn)
    if (!iresetn) r_ir_sh <= '0;
    else if (bus.tck_en && w_state == CAP_IR) r_ir_sh <= IR_W'(2'b01);
    else if (bus.tck_en && w_shi) r_ir_sh <= {bus.tdi, r_ir_sh[IR_W-1:1]};
  always_ff @(posedge iclk or negedge iresetn)
    if (!iresetn) r_byp <= 1'b0;
    else if (bus.tck_en && w_state == CAP_DR && !w_bsr_sel) r_byp <= 1'b0;
    else if (bus.tck_en && w_shd) r_byp <= bus.tdi;
  assign bus.tdo_oe    = w_shd || w_shi;
  assign bus.tdo       = w_shi ? r_ir_sh[0] : w_shd ? (w_bsr_sel ? bus.bsr_sdo : r_byp) : 1'b0;
  assign bus.bsr_sdi   = bus.tdi;
  assign bus.mode      = (r_ir == OP_EXTEST);
  assign bus.shift_dr  = w_shd && w_bsr_sel;
  assign bus.clk_dr    = bus.tck_en && (w_shd || w_state == CAP_DR) && w_bsr_sel;
  assign bus.update_dr = bus.tck_en && (w_state == UPDATE_DR) && w_bsr_sel;
  assign bus.tap_state = w_state;
endmodule
